seg7_scan_n: RTL and testbench
==============================

# seg7_scan_n

Parametrised multiplexed seven-segment display driver, successor to the fixed 4-digit score display. Scans NUM_DIGITS common-anode digits from a latched hex value, with per-digit decimal points, blanking, blinking and leading-zero suppression. Sits between game/score logic and the board's anode/segment pins; all outputs are active-low and registered.

## Interface
- NUM_DIGITS, 4, digits scanned (legal 2..8)
- SCAN_DIV_BITS, 18, prescaler width; each digit is held for 2^SCAN_DIV_BITS cycles
- BLINK_DIV_BITS, 24, blink counter width; blink phase = counter MSB
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- value  in  4*NUM_DIGITS  hex nibbles; nibble i = value[4i+3:4i], digit 0 least significant
- dp_mask  in  NUM_DIGITS  bit i lights decimal point of digit i
- load  in  1  when high at a clk edge, value and dp_mask are captured into shadow registers
- blank_mask  in  NUM_DIGITS  bit i forces digit i dark (live, not latched)
- blink_mask  in  NUM_DIGITS  bit i blanks digit i during blink phase 1 (live)
- lz_suppress  in  1  enable leading-zero suppression (live)
- anode  out  NUM_DIGITS  active-low digit enables; anode[i]=0 selects digit i
- digit_seg  out  8  active-low segments; bit0..6 = a..g, bit7 = dp
- scan_tick  out  1  one-cycle pulse when the scan index advances

## Operation
- Shadow registers: shadow_val, shadow_dp; reset to 0; written only when load=1. Display uses shadow only, so mid-scan input changes never glitch the display.
- Prescaler: SCAN_DIV_BITS-bit up-counter, free-running, wraps to 0. When prescaler is all ones, idx increments next edge; idx NUM_DIGITS-1 wraps to 0. Non-power-of-two NUM_DIGITS must wrap explicitly.
- Blink counter: BLINK_DIV_BITS-bit free-running; phase = MSB.
- Per-edge output register update from current idx i:
  - anode = all ones except bit i = 0 (anode sequencing never stops, even for dark digits).
  - dark if blank_mask[i], or (blink_mask[i] and phase=1), or (lz_suppress and i≠0 and shadow nibbles i..NUM_DIGITS-1 all zero).
  - dark → digit_seg = 8'hFF (dp also off).
  - else digit_seg[6:0] = glyph(nibble i), digit_seg[7] = ~shadow_dp[i].
- Glyphs (bit7 shown as 1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. Nibble F displays "F" (no implicit blank code; blanking only via masks).
- Digit 0 is never suppressed by lz_suppress (value 0 shows "0").
- scan_tick registered: high for the cycle following the edge where idx advances.

## Timing
- Reset (rst high at edge): prescaler, blink counter, idx, shadow regs, scan_tick = 0; anode = all ones; digit_seg = 8'hFF. Reset wins over load the same cycle.
- First edge with rst low: outputs show digit 0 (anode = ...1110).
- Output latency: one cycle from idx/shadow/mask state to pins.
- load at edge k → shadow updated at k → pins reflect at edge k+1 (if that digit is selected).
- Live masks: change at edge k visible at edge k+1.
- Digit dwell: exactly 2^SCAN_DIV_BITS cycles per digit; full frame NUM_DIGITS × that.
- Blink: each phase lasts 2^(BLINK_DIV_BITS-1) cycles.
- Reset asserted mid-scan returns to idx 0 and blank outputs on the same edge.

## Test plan
- NUM_DIGITS=4, SCAN_DIV_BITS=2: reset, then load value=16'h12AF, dp_mask=0 → anode cycles 1110,1101,1011,0111 every 4 cycles; segs 8E,88,A4,F9; scan_tick pulses every 4 cycles.
- Load 16'h0050 with lz_suppress=1 → digits 3,2 = FF; digit1 = 92; digit0 = C0. Load 0 → only digit0 = C0.
- dp_mask=4'b0010 with value 16'h3333 → digit1 seg = 30, others B0; blank_mask=4'b0001 → digit0 FF, anode still pulses 1110.
- BLINK_DIV_BITS=5, blink_mask=4'b1000 → digit3 alternates glyph/FF every 16 cycles; other digits steady.
- Change value without load mid-frame → pins unchanged; pulse load → next selected digit shows new glyph one cycle later; load and rst same edge → shadow stays 0.
- NUM_DIGITS=6: idx wraps 5→0, anode never shows an all-ones or multi-zero pattern after reset.

Source files
------------

// File: rtl/seg7_scan_n_if.sv
// Bus bundle for the multiplexed seven-segment driver.
// Parameter NUM_DIGITS sizes the per-digit fields.
// Fields: value, dp_mask and load are the display-data inputs, captured on load.
// blank_mask, blink_mask and lz_suppress are live display controls.
// anode, digit_seg and scan_tick are the registered, active-low pin drives
// and the scan-advance pulse.
// The master modport drives data in; the slave modport is the driver itself.
interface seg7_scan_n_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    load;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_suppress;
  logic [NUM_DIGITS-1:0]   anode;
  logic [7:0]              digit_seg;
  logic                    scan_tick;

  modport master (
    output value, dp_mask, load, blank_mask, blink_mask, lz_suppress,
    input  anode, digit_seg, scan_tick
  );

  modport slave (
    input  value, dp_mask, load, blank_mask, blink_mask, lz_suppress,
    output anode, digit_seg, scan_tick
  );
endinterface

// File: rtl/seg7_scan_n.sv
// Multiplexed common-anode seven-segment driver for NUM_DIGITS digits.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - seg7_scan_n_if slave. It carries the hex value, dp mask and load
//          strobe, which are shadowed. It carries the live blank, blink and
//          leading-zero controls. It also carries the registered active-low
//          anode and segment pins and the scan_tick pulse.
// Parameters: NUM_DIGITS (2..8).
//   SCAN_DIV_BITS: each digit dwells 2^SCAN_DIV_BITS cycles.
//   BLINK_DIV_BITS: the blink phase is the MSB of a free-running counter.
module seg7_scan_n #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV_BITS  = 18,
  parameter int BLINK_DIV_BITS = 24
) (
  input  logic          clk,
  input  logic          rst,
  seg7_scan_n_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0]  presc;
  logic [BLINK_DIV_BITS-1:0] blink_cnt;
  logic [IDX_W-1:0]          idx;
  logic [4*NUM_DIGITS-1:0]   shadow_val;
  logic [NUM_DIGITS-1:0]     shadow_dp;

  logic [NUM_DIGITS-1:0]     anode_p1;
  logic [7:0]                seg_p1;
  logic                      tick_p1;

  logic [NUM_DIGITS:0]       zero_from;
  logic [3:0]                nib_p0;
  logic                      dark_p0;
  logic                      phase_p0;
  logic [NUM_DIGITS-1:0]     anode_p0;
  logic [7:0]                seg_p0;

  // Active-low a..g pattern for one hex nibble; bit 7 (dp) is handled separately.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Stage p0: decode the currently selected digit from shadow state and live masks.
  always_comb begin
    // zero_from[i] is set when nibbles i..NUM_DIGITS-1 are all zero; the extra
    // top bit seeds the chain so no out-of-range index is ever needed.
    zero_from = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = (shadow_val[4*i +: 4] == 4'h0) && zero_from[i+1];
    end

    phase_p0 = blink_cnt[BLINK_DIV_BITS-1];
    nib_p0   = shadow_val[4*int'(idx) +: 4];
    dark_p0  = bus.blank_mask[idx]
             | (bus.blink_mask[idx] & phase_p0)
             | (bus.lz_suppress & (idx != '0) & zero_from[idx]);
    anode_p0 = ~(NUM_DIGITS'(1) << idx);
    seg_p0   = dark_p0 ? 8'hFF : {~shadow_dp[idx], glyph(nib_p0)};
  end

  // Stage p1: counters, shadow capture and registered pin drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      blink_cnt  <= '0;
      idx        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      tick_p1    <= 1'b0;
      anode_p1   <= '1;
      seg_p1     <= 8'hFF;
    end else begin
      presc     <= presc + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      // Explicit wrap so non-power-of-two digit counts never select a ghost digit.
      if (&presc) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      tick_p1 <= &presc;
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_mask;
      end
      anode_p1 <= anode_p0;
      seg_p1   <= seg_p0;
    end
  end

  assign bus.anode     = anode_p1;
  assign bus.digit_seg = seg_p1;
  assign bus.scan_tick = tick_p1;

endmodule

// File: tb/tb_seg7_scan_n.sv
// Bench for seg7_scan_n. A 4-digit instance (dwell 4, blink phase 16) receives
// the directed scenarios. A 6-digit instance (dwell 2, constant load) shares
// clk/rst and exercises the non-power-of-two wrap.
module tb_seg7_scan_n;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seg7_scan_n_if #(.NUM_DIGITS(4)) bus4 ();
  seg7_scan_n_if #(.NUM_DIGITS(6)) bus6 ();

  seg7_scan_n #(.NUM_DIGITS(4), .SCAN_DIV_BITS(2), .BLINK_DIV_BITS(5)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  seg7_scan_n #(.NUM_DIGITS(6), .SCAN_DIV_BITS(1), .BLINK_DIV_BITS(4)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  typedef struct {
    int         id;
    int         e;
    logic [3:0] an;
    logic [7:0] seg;
    logic       tk;
    logic [5:0] an6;
    logic [7:0] seg6;
    logic       tk6;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Glyphs of the 6-digit instance's fixed value 24'h987650, digit 0 first.
  logic [7:0] tab6 [6] = '{8'hC0, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Monitor: pops one expected entry per output sample and compares both DUTs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if ({bus4.anode, bus4.digit_seg, bus4.scan_tick} !== {x.an, x.seg, x.tk}) begin
        errors++;
        $display("FAIL s%0d e%0d dut4 got an=%b seg=%h tk=%b want an=%b seg=%h tk=%b",
                 x.id, x.e, bus4.anode, bus4.digit_seg, bus4.scan_tick, x.an, x.seg, x.tk);
      end
      checks++;
      if ({bus6.anode, bus6.digit_seg, bus6.scan_tick} !== {x.an6, x.seg6, x.tk6}) begin
        errors++;
        $display("FAIL s%0d e%0d dut6 got an=%b seg=%h tk=%b want an=%b seg=%h tk=%b",
                 x.id, x.e, bus6.anode, bus6.digit_seg, bus6.scan_tick, x.an6, x.seg6, x.tk6);
      end
    end
  end

  // Resets both DUTs (with load high, which must lose), loads val at the first
  // edge, then runs 16*frames edges. segs_a/segs_b hold hand-computed glyphs,
  // digit d in bits [8d+:8]. If load2_edge is non-zero, value switches to val2
  // from edge 3 without load, and load is pulsed only at edge load2_edge.
  task automatic run_scn(input int id, input logic [15:0] val, input logic [3:0] dp,
                         input logic [3:0] blank, input logic [3:0] blink, input logic lz,
                         input logic [31:0] segs_a, input logic [15:0] val2,
                         input logic [31:0] segs_b, input int load2_edge, input int frames);
    exp_t x;
    int d;
    int d6;
    bus4.value       = val;
    bus4.dp_mask     = dp;
    bus4.blank_mask  = blank;
    bus4.blink_mask  = blink;
    bus4.lz_suppress = lz;
    bus4.load        = 1'b1;
    rst              = 1'b1;
    @(posedge clk);
    x = '{id: id, e: 0, an: 4'hF, seg: 8'hFF, tk: 1'b0, an6: 6'h3F, seg6: 8'hFF, tk6: 1'b0};
    q.push_back(x);
    #1;
    rst       = 1'b0;
    bus4.load = 1'b1;
    for (int e = 1; e <= 16 * frames; e++) begin
      @(posedge clk);
      d  = ((e - 1) / 4) % 4;
      d6 = ((e - 1) / 2) % 6;
      x.id  = id;
      x.e   = e;
      x.an  = ~(4'b0001 << d);
      x.seg = (load2_edge != 0 && e > load2_edge) ? segs_b[8*d +: 8] : segs_a[8*d +: 8];
      // Edge 1 still shows the freshly reset shadow (zero) on digit 0.
      if (e == 1) x.seg = blank[0] ? 8'hFF : 8'hC0;
      if (blink[d] && ((((e - 1) >> 4) & 1) == 1)) x.seg = 8'hFF;
      x.tk   = (e % 4 == 0);
      x.an6  = ~(6'b000001 << d6);
      x.seg6 = tab6[d6];
      x.tk6  = (e % 2 == 0);
      q.push_back(x);
      #1;
      bus4.load = (load2_edge != 0) && (e + 1 == load2_edge);
      if (load2_edge != 0 && e + 1 >= 3) bus4.value = val2;
    end
  endtask

  initial begin
    bus4.value       = '0;
    bus4.dp_mask     = '0;
    bus4.load        = 1'b0;
    bus4.blank_mask  = '0;
    bus4.blink_mask  = '0;
    bus4.lz_suppress = 1'b0;
    bus6.value       = 24'h987650;
    bus6.dp_mask     = '0;
    bus6.load        = 1'b1;
    bus6.blank_mask  = '0;
    bus6.blink_mask  = '0;
    bus6.lz_suppress = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Basic scan of 12AF.
    run_scn(1, 16'h12AF, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'hF9A4888E, 16'h0, 32'h0, 0, 1);
    // Leading-zero suppression: 0050, then all zero.
    run_scn(2, 16'h0050, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'hFFFF92C0, 16'h0, 32'h0, 0, 1);
    run_scn(3, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'hFFFFFFC0, 16'h0, 32'h0, 0, 1);
    // Inner zero stays lit under suppression.
    run_scn(4, 16'h0805, 4'b0000, 4'b0000, 4'b0000, 1'b1, 32'hFF80C092, 16'h0, 32'h0, 0, 1);
    // Decimal point on digit 1, then with digit 0 blanked.
    run_scn(5, 16'h3333, 4'b0010, 4'b0000, 4'b0000, 1'b0, 32'hB0B030B0, 16'h0, 32'h0, 0, 1);
    run_scn(6, 16'h3333, 4'b0010, 4'b0001, 4'b0000, 1'b0, 32'hB0B030FF, 16'h0, 32'h0, 0, 1);
    // Blink digit 3 over four frames.
    run_scn(7, 16'h12AF, 4'b0000, 4'b0000, 4'b1000, 1'b0, 32'hF9A4888E, 16'h0, 32'h0, 0, 4);
    // Value change without load is ignored; load at edge 6 takes effect at edge 7.
    run_scn(8, 16'h12AF, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'hF9A4888E,
            16'h3333, 32'hB0B0B0B0, 6, 1);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
